servo_axi_slave: RTL
====================

Name: servo_axi_slave

Overview:
- AXI4-Lite slave (responder) holding the servo register bank, plus the PWM pulse generator those registers control.
- Sits behind the system interconnect as the target the AXI master drives. Four 32-bit read/write registers at 0x0, 0x4, 0x8 and 0xC.
- Drives one servo PWM output. Timing values are double-buffered so that pulse updates never glitch mid-frame.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 4, AXI byte-address width; bits [3:2] select the register
CNT_WIDTH, 20, width of the functional PERIOD/PULSE fields and the frame counter

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  always 2'b00 (OKAY)
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  always 2'b00
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
pwm_out  out  1  servo PWM output
period_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset: one clock; reset is asynchronous, active-low (s00_axi_aresetn), clocked on s00_axi_aclk.
  - During reset, all outputs are 0 and all registers, shadows, counters and the prescaler are 0.
- Register map: bits [3:2] of the address select the register; bits [1:0] are ignored.
  - 0x0 CTRL: bit0 = en.
  - 0x4 PERIOD.
  - 0x8 PULSE.
  - 0xC PRESC.
  - All four store the full 32 bits and read back exactly what was written.
  - Functional use: CTRL[0], PERIOD[CNT_WIDTH-1:0], PULSE[CNT_WIDTH-1:0], PRESC[15:0].
- Write channel:
  - awready and wready rise together for exactly one cycle when awvalid && wvalid && !bvalid && !awready are all true. AW arriving before W, or W before AW, simply waits.
  - On that handshake edge, the addressed register updates byte-wise per wstrb.
  - bvalid asserts on the next cycle and holds until bready; no new write is accepted while bvalid is high.
- Read channel:
  - arready pulses for one cycle when arvalid && !rvalid && !arready.
  - rdata is registered and rvalid asserts on the next cycle. Both hold stable until rready.
  - Read and write channels are independent. If a read and a write hit the same register in the same cycle, the read returns the old value.
- Prescaler: when en=1, a tick is generated every PRESC+1 clocks. PRESC=0 means a tick every clock.
- Frame counter cnt:
  - Increments on each tick.
  - When cnt==period_sh and a tick occurs: cnt wraps to 0, period_sh/pulse_sh reload from PERIOD/PULSE, and period_tick pulses for one cycle.
  - A frame is period_sh+1 ticks long.
- Shadow registers: loaded from the live registers on the wrap, and also on the cycle en transitions 0->1. That same cycle clears cnt and the prescaler.
  - Register writes made mid-frame affect only the next frame.
- pwm_out is registered: pwm_out <= en && (cnt < pulse_sh), i.e. it lags cnt by one clock.
  - PULSE=0 gives constant low.
  - PULSE>PERIOD gives constant high while enabled.
  - PERIOD=0 gives 1-tick frames.
- Disable (CTRL[0] written 0): on the following clock, cnt, the prescaler and pwm_out go to 0. Registers are retained.
- Reset asserted mid-transaction or mid-frame: everything returns to reset values immediately. Any in-flight AXI transaction is dropped and no response is issued.

Test Plan:
- Reset -> all AXI ready/valid outputs and pwm_out are 0; reads of 0x0..0xC return 0.
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC; read back in order -> rdata 0x1, 0x2, 0x3, 0x4, all responses OKAY.
- Write 0xAABBCCDD to 0x8, then 0x11223344 with wstrb=4'b0101 -> read returns 0xAA22CC44.
- AW valid 3 cycles before W, with bready held low 5 cycles -> single handshake; bvalid held 5 cycles, then clears; no second write accepted meanwhile.
- PRESC=0, PERIOD=9, PULSE=3, then CTRL=1 -> pwm_out high 3 clocks out of every 10; period_tick every 10 clocks.
  - Writing PULSE=7 mid-frame -> current frame stays at 3, next frame is 7.
- Enabled with PRESC=1, PERIOD=4, PULSE=2 -> high 4 clocks per 10-clock frame.
  - Deassert s00_axi_aresetn mid-frame -> pwm_out 0 asynchronously; after release, registers read 0.

Source files
------------

// File: rtl/servo_axi_slave_if.sv
// servo_axi_slave_if: AXI4-Lite bus between the interconnect master and the servo register slave
interface servo_axi_slave_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/servo_axi_slave.sv
// servo_axi_slave: AXI4-Lite register bank driving a double-buffered servo PWM generator
module servo_axi_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int CNT_WIDTH = 20
) (
   input  logic               s00_axi_aclk,
   input  logic               s00_axi_aresetn,
   servo_axi_slave_if.slave   s00_axi,
   output logic               pwm_out,
   output logic               period_tick
);
   logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
   logic [CNT_WIDTH-1:0] cnt, period_sh, pulse_sh;
   logic [15:0] pres;
   logic en, en_d, tick, wr_go, unused;
   assign en = regs[0][0];
   assign tick = en && pres == regs[3][15:0];
   assign wr_go = s00_axi.awready && s00_axi.awvalid && s00_axi.wvalid;
   assign s00_axi.wready = s00_axi.awready;
   assign s00_axi.bresp = 2'b00;
   assign s00_axi.rresp = 2'b00;
   assign unused = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         s00_axi.awready <= 1'b0;
         s00_axi.bvalid <= 1'b0;
         s00_axi.arready <= 1'b0;
         s00_axi.rvalid <= 1'b0;
         s00_axi.rdata <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         s00_axi.awready <= s00_axi.awvalid && s00_axi.wvalid && !s00_axi.bvalid && !s00_axi.awready;
         s00_axi.bvalid <= wr_go || (s00_axi.bvalid && !s00_axi.bready);
         s00_axi.arready <= s00_axi.arvalid && !s00_axi.rvalid && !s00_axi.arready;
         if (s00_axi.arready && s00_axi.arvalid) begin
            s00_axi.rvalid <= 1'b1;
            s00_axi.rdata <= regs[s00_axi.araddr[3:2]];
         end else if (s00_axi.rvalid && s00_axi.rready) s00_axi.rvalid <= 1'b0;
         if (wr_go)
            for (int i = 0; i < 4; i++)
               if (s00_axi.wstrb[i]) regs[s00_axi.awaddr[3:2]][8*i +: 8] <= s00_axi.wdata[8*i +: 8];
      end
   end
   // shadows reload on enable rise and at frame wrap so a frame never changes mid-pulse
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         cnt <= '0;
         pres <= '0;
         period_sh <= '0;
         pulse_sh <= '0;
         en_d <= 1'b0;
         pwm_out <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         en_d <= en;
         period_tick <= 1'b0;
         pwm_out <= en && cnt < pulse_sh;
         if (!en) begin
            cnt <= '0;
            pres <= '0;
         end else if (!en_d) begin
            cnt <= '0;
            pres <= '0;
            period_sh <= regs[1][CNT_WIDTH-1:0];
            pulse_sh <= regs[2][CNT_WIDTH-1:0];
         end else if (tick) begin
            pres <= '0;
            if (cnt == period_sh) begin
               cnt <= '0;
               period_sh <= regs[1][CNT_WIDTH-1:0];
               pulse_sh <= regs[2][CNT_WIDTH-1:0];
               period_tick <= 1'b1;
            end else cnt <= cnt + 1'b1;
         end else pres <= pres + 1'b1;
      end
   end
endmodule
